// File: rtl/tt_um_count_monitor_if.sv
// Bundles the count-monitor pin group.
//   ena     : design enable
//   ui_in   : count bus from the external counter (asynchronous to clk)
//   uio_in  : [1:0] readout select, [3] sticky-flag clear
//   uo_out  : selected readout
//   uio_out : unused, driven 0
//   uio_oe  : all uio pins are inputs, driven 0
interface tt_um_count_monitor_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_count_monitor.sv
// Monitors an external free-running binary counter seen on ui_in. The bus is synchronised,
// debounced (a value must hold STABLE_CYCLES samples), then each accepted value is classified
// as a good +1 step, a restart to zero, or an error. Good steps are counted over a window of
// 2^GATE_LOG2 clocks to give a rate readout.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of tt_um_count_monitor_if (ena, ui_in, uio_in, uo_out, uio_out, uio_oe)
module tt_um_count_monitor #(
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned GATE_LOG2     = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  tt_um_count_monitor_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAcquire, StTrack} state_e;

  localparam logic [3:0] StableThr = 4'(STABLE_CYCLES);
  localparam logic [GATE_LOG2-1:0] WinOne = {{(GATE_LOG2-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [7:0]           s1_q, s2_q;
  logic [7:0]           last_q, last_d;
  logic [3:0]           stab_q, stab_d;
  logic [8:0]           step_q, step_d;
  logic [7:0]           err_q, err_d;
  logic [7:0]           rate_q, rate_d;
  logic [GATE_LOG2-1:0] win_q, win_d;
  logic                 err_flag_q, err_flag_d;
  logic                 restart_q, restart_d;
  logic                 stall_q, stall_d;
  logic                 seen_q, seen_d;

  logic       clr;
  logic       active, accept, good, restart_evt, error_evt, terminal;
  logic [8:0] step_inc;

  assign clr = bus.uio_in[3];

  always_comb begin
    // Stability run length of s2; a change starts a new run of one sample.
    stab_d = (s1_q != s2_q) ? 4'd1 : ((stab_q == 4'hf) ? stab_q : stab_q + 4'd1);

    active      = bus.ena && (state_q != StIdle);
    accept      = active && (stab_q >= StableThr) && (s2_q != last_q);
    good        = accept && (state_q == StTrack) && (s2_q == last_q + 8'd1);
    restart_evt = accept && (state_q == StTrack) && !good && (s2_q == 8'd0);
    error_evt   = accept && (state_q == StTrack) && !good && !restart_evt;
    terminal    = active && (&win_q);

    step_inc = (good && (step_q != 9'd256)) ? step_q + 9'd1 : step_q;

    last_d     = accept ? s2_q : last_q;
    win_d      = active ? win_q + WinOne : win_q;
    step_d     = terminal ? 9'd0 : step_inc;
    rate_d     = terminal ? ((step_inc > 9'd255) ? 8'hff : step_inc[7:0]) : rate_q;
    // The accept landing on the terminal cycle still belongs to the closing window.
    seen_d     = terminal ? 1'b0 : (seen_q | accept);
    stall_d    = terminal ? !(seen_q | accept) : stall_q;
    err_d      = (error_evt && (err_q != 8'hff)) ? err_q + 8'd1 : err_q;
    err_flag_d = err_flag_q | error_evt;
    restart_d  = restart_q | restart_evt;

    // Clear beats any same-edge setting event and acts even while idle.
    if (clr) begin
      err_d      = 8'd0;
      err_flag_d = 1'b0;
      restart_d  = 1'b0;
      stall_d    = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    state_d = StAcquire;
      StAcquire: if (accept) state_d = StTrack;
      StTrack:   state_d = StTrack;
      default:   state_d = StIdle;
    endcase
    if (!bus.ena) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= bus.ena ? StAcquire : StIdle;
      s1_q       <= 8'd0;
      s2_q       <= 8'd0;
      last_q     <= 8'd0;
      stab_q     <= 4'd0;
      step_q     <= 9'd0;
      err_q      <= 8'd0;
      rate_q     <= 8'd0;
      win_q      <= '0;
      err_flag_q <= 1'b0;
      restart_q  <= 1'b0;
      stall_q    <= 1'b0;
      seen_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= bus.ui_in;
      s2_q       <= s1_q;
      last_q     <= last_d;
      stab_q     <= stab_d;
      step_q     <= step_d;
      err_q      <= err_d;
      rate_q     <= rate_d;
      win_q      <= win_d;
      err_flag_q <= err_flag_d;
      restart_q  <= restart_d;
      stall_q    <= stall_d;
      seen_q     <= seen_d;
    end
  end

  always_comb begin
    bus.uo_out = 8'd0;
    unique case (bus.uio_in[1:0])
      2'd0: bus.uo_out = last_q;
      2'd1: bus.uo_out = err_q;
      2'd2: bus.uo_out = rate_q;
      2'd3: bus.uo_out = {2'b00, stall_q, (err_q == 8'hff), (rate_q == 8'hff),
                          restart_q, err_flag_q, (state_q == StTrack)};
      default: bus.uo_out = 8'd0;
    endcase
  end

  assign bus.uio_out = 8'd0;
  assign bus.uio_oe  = 8'd0;

endmodule
